vram_port_arbiter: RTL and testbench

- Shares the single-port text-mode VRAM block RAM between two requesters: the AXI4-Lite register/VRAM slave (CPU reads and writes) and the HDMI text scan-out engine (character/attribute fetches).
- Grants at most one access per cycle, drives the RAM port and returns read data to the correct owner after the fixed RAM read latency.
- Video has priority; a starvation guard guarantees AXI forward progress.

---
 rtl/vram_port_arbiter_if.sv | 49 ++++
 rtl/vram_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_vram_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_port_arbiter_if.sv
// Bus bundle between the VRAM port arbiter, its two requesters and the RAM.
//   AXI side  : axi_req/axi_we/axi_addr/axi_wdata/axi_wstrb in,
//               axi_gnt/axi_rvalid/axi_rdata out
//   Video side: vid_req/vid_addr in, vid_gnt/vid_rvalid/vid_rdata out
//   RAM side  : mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in
// The slave modport is the arbiter's view; master is the environment's view.
interface vram_port_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic                  axi_req;
  logic                  axi_we;
  logic [ADDR_W-1:0]     axi_addr;
  logic [DATA_W-1:0]     axi_wdata;
  logic [DATA_W/8-1:0]   axi_wstrb;
  logic                  axi_gnt;
  logic                  axi_rvalid;
  logic [DATA_W-1:0]     axi_rdata;

  logic                  vid_req;
  logic [ADDR_W-1:0]     vid_addr;
  logic                  vid_gnt;
  logic                  vid_rvalid;
  logic [DATA_W-1:0]     vid_rdata;

  logic                  mem_en;
  logic [DATA_W/8-1:0]   mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  axi_req, axi_we, axi_addr, axi_wdata, axi_wstrb,
    output axi_gnt, axi_rvalid, axi_rdata,
    input  vid_req, vid_addr,
    output vid_gnt, vid_rvalid, vid_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output axi_req, axi_we, axi_addr, axi_wdata, axi_wstrb,
    input  axi_gnt, axi_rvalid, axi_rdata,
    output vid_req, vid_addr,
    input  vid_gnt, vid_rvalid, vid_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// Shares the single-port text-mode VRAM between the AXI register/VRAM slave
// and the HDMI scan-out engine. One access per cycle is granted
// combinationally; video has priority, but after MAX_VID_BURST consecutive
// video grants against a waiting AXI request the next slot is forced to AXI.
// Read data is routed back to its owner RD_LAT+1 cycles after the grant.
// Ports:
//   S_AXI_ACLK    sole clock
//   S_AXI_ARESET  synchronous active-high reset
//   bus           vram_port_arbiter_if.slave (requests, grants, RAM port)
//   starve_events saturating count of forced AXI grants
module vram_port_arbiter #(
  parameter int ADDR_W        = 11,
  parameter int DATA_W        = 32,
  parameter int RD_LAT        = 2,
  parameter int MAX_VID_BURST = 8
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESET,
  vram_port_arbiter_if.slave   bus,
  output logic [15:0]          starve_events
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [7:0] MAX_RUN = 8'(MAX_VID_BURST);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic              force_axi;
  logic [7:0]        vid_run;
  logic [7:0]        vid_run_nxt;
  logic              axi_gnt_c;
  logic              vid_gnt_c;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [BE_W-1:0]   win_we;

  // Request cycle: combinational grant and RAM drive
  always_comb begin
    vid_gnt_c = 1'b0;
    axi_gnt_c = 1'b0;
    if (!S_AXI_ARESET) begin
      // force_axi only ever matters while AXI is actually waiting
      if (bus.vid_req && !(force_axi && bus.axi_req)) begin
        vid_gnt_c = 1'b1;
      end else if (bus.axi_req) begin
        axi_gnt_c = 1'b1;
      end
    end
  end

  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_we    = '0;
    if (axi_gnt_c) begin
      win_addr  = bus.axi_addr;
      win_wdata = bus.axi_wdata;
      win_we    = bus.axi_we ? bus.axi_wstrb : '0;
    end else if (vid_gnt_c) begin
      win_addr  = bus.vid_addr;
    end
  end

  assign bus.axi_gnt   = axi_gnt_c;
  assign bus.vid_gnt   = vid_gnt_c;
  assign bus.mem_en    = axi_gnt_c | vid_gnt_c;
  assign bus.mem_we    = win_we;
  assign bus.mem_addr  = win_addr;
  assign bus.mem_wdata = win_wdata;

  // Run length of video grants taken while AXI is waiting
  always_comb begin
    vid_run_nxt = vid_run;
    if (axi_gnt_c || !bus.axi_req) begin
      vid_run_nxt = 8'd0;
    end else if (vid_gnt_c) begin
      vid_run_nxt = vid_run + 8'd1;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      vid_run       <= 8'd0;
      force_axi     <= 1'b0;
      starve_events <= 16'd0;
    end else begin
      vid_run <= vid_run_nxt;
      // Set on the grant that completes the burst so the very next slot is AXI's
      if (axi_gnt_c) begin
        force_axi <= 1'b0;
      end else if (vid_gnt_c && (vid_run_nxt == MAX_RUN)) begin
        force_axi <= 1'b1;
      end
      if (axi_gnt_c && force_axi) begin
        starve_events <= sat_inc16(starve_events);
      end
    end
  end

  // Read return pipeline: stage 0 loaded at grant, stage RD_LAT-1 aligned with mem_rdata
  logic [RD_LAT-1:0] vld_p;
  logic [RD_LAT-1:0] own_p;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= vid_gnt_c | (axi_gnt_c & ~bus.axi_we);
      for (int i = 1; i < RD_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    own_p[0] <= vid_gnt_c;
    for (int i = 1; i < RD_LAT; i++) begin
      own_p[i] <= own_p[i-1];
    end
  end

  // Output stage: route RAM data to its owner
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      bus.axi_rvalid <= 1'b0;
      bus.vid_rvalid <= 1'b0;
      bus.axi_rdata  <= '0;
      bus.vid_rdata  <= '0;
    end else begin
      bus.axi_rvalid <= vld_p[RD_LAT-1] & ~own_p[RD_LAT-1];
      bus.vid_rvalid <= vld_p[RD_LAT-1] &  own_p[RD_LAT-1];
      if (vld_p[RD_LAT-1] && !own_p[RD_LAT-1]) begin
        bus.axi_rdata <= bus.mem_rdata;
      end
      if (vld_p[RD_LAT-1] && own_p[RD_LAT-1]) begin
        bus.vid_rdata <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: randomized and directed requester traffic,
// a read-first RAM model on the RAM port, and a reference model that tracks
// arbitration fairness, starvation count and expected read responses.
module tb_vram_port_arbiter;
  localparam int ADDR_W        = 11;
  localparam int DATA_W        = 32;
  localparam int RD_LAT        = 2;
  localparam int MAX_VID_BURST = 8;

  logic        S_AXI_ACLK = 1'b0;
  logic        S_AXI_ARESET = 1'b1;
  logic [15:0] starve_events;

  vram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_VID_BURST(MAX_VID_BURST)
  ) dut (
    .S_AXI_ACLK(S_AXI_ACLK),
    .S_AXI_ARESET(S_AXI_ARESET),
    .bus(bus.slave),
    .starve_events(starve_events)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  // RAM model: read-first, data valid RD_LAT cycles after mem_en
  logic [DATA_W-1:0] ram   [2048];
  logic [DATA_W-1:0] ram_q [RD_LAT];

  always @(posedge S_AXI_ACLK) begin
    if (bus.mem_en) begin
      ram_q[0] <= ram[bus.mem_addr];
      for (int b = 0; b < DATA_W/8; b++) begin
        if (bus.mem_we[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
    end
    for (int i = 1; i < RD_LAT; i++) ram_q[i] <= ram_q[i-1];
  end
  assign bus.mem_rdata = ram_q[RD_LAT-1];

  // Reference model state
  typedef struct {
    bit          vid;
    logic [31:0] data;
    int          due;
  } resp_t;

  resp_t       rq[$];
  logic [31:0] shadow [2048];
  int          cyc = 0;
  int          ref_waits = 0;
  int          ref_starve = 0;
  bit          prev_rst = 1'b0;
  bit          g_axi, g_vid;
  bit          o_axi, o_vid, o_vrv, o_men;
  bit          a_pend = 1'b0;
  bit          v_pend = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Entered at posedge+1 with this cycle's inputs applied; checks at the
  // falling edge, advances the model across the rising edge.
  task automatic step();
    resp_t       h;
    resp_t       r;
    bit          ev_axi, ev_vid;
    logic [31:0] ed;
    #4;
    g_vid = !S_AXI_ARESET && bus.vid_req && !(bus.axi_req && ref_waits >= MAX_VID_BURST);
    g_axi = !S_AXI_ARESET && bus.axi_req && !g_vid;
    o_axi = bus.axi_gnt;
    o_vid = bus.vid_gnt;
    o_vrv = bus.vid_rvalid;
    o_men = bus.mem_en;
    ev_axi = 1'b0;
    ev_vid = 1'b0;
    ed     = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      h = rq.pop_front();
      ev_vid = h.vid;
      ev_axi = !h.vid;
      ed     = h.data;
    end
    if (cyc > 0) begin
      chk("axi_gnt", bus.axi_gnt, g_axi);
      chk("vid_gnt", bus.vid_gnt, g_vid);
      chk("gnt_excl", bus.axi_gnt & bus.vid_gnt, 0);
      chk("mem_en", bus.mem_en, g_axi | g_vid);
      chk("mem_we", bus.mem_we, (g_axi && bus.axi_we) ? bus.axi_wstrb : 4'h0);
      if (g_axi) chk("mem_addr_axi", bus.mem_addr, bus.axi_addr);
      if (g_vid) chk("mem_addr_vid", bus.mem_addr, bus.vid_addr);
      if (g_axi && bus.axi_we) chk("mem_wdata", bus.mem_wdata, bus.axi_wdata);
      chk("axi_rvalid", bus.axi_rvalid, ev_axi);
      chk("vid_rvalid", bus.vid_rvalid, ev_vid);
      if (ev_axi) chk("axi_rdata", bus.axi_rdata, ed);
      if (ev_vid) chk("vid_rdata", bus.vid_rdata, ed);
      if (prev_rst) begin
        chk("rst_axi_rdata", bus.axi_rdata, 0);
        chk("rst_vid_rdata", bus.vid_rdata, 0);
      end
      chk("starve_events", starve_events, ref_starve);
    end
    if (S_AXI_ARESET) begin
      ref_waits  = 0;
      ref_starve = 0;
      rq.delete();
    end else begin
      if (g_axi) begin
        if (ref_waits >= MAX_VID_BURST && ref_starve < 65535) ref_starve++;
        ref_waits = 0;
        if (bus.axi_we) begin
          for (int b = 0; b < 4; b++)
            if (bus.axi_wstrb[b]) shadow[bus.axi_addr][8*b +: 8] = bus.axi_wdata[8*b +: 8];
        end else begin
          r.vid = 1'b0; r.data = shadow[bus.axi_addr]; r.due = cyc + RD_LAT + 1;
          rq.push_back(r);
        end
      end else if (!bus.axi_req) begin
        ref_waits = 0;
      end else if (g_vid) begin
        ref_waits++;
      end
      if (g_vid) begin
        r.vid = 1'b1; r.data = shadow[bus.vid_addr]; r.due = cyc + RD_LAT + 1;
        rq.push_back(r);
      end
    end
    prev_rst = S_AXI_ARESET;
    @(posedge S_AXI_ACLK);
    #1;
    cyc++;
  endtask

  task automatic axi_issue(input bit we, input logic [10:0] addr,
                           input logic [31:0] wd, input logic [3:0] ws);
    int t;
    t = 0;
    bus.axi_req = 1'b1; bus.axi_we = we; bus.axi_addr = addr;
    bus.axi_wdata = wd; bus.axi_wstrb = ws;
    do begin
      step();
      t++;
    end while (!g_axi && t < 100);
    if (!g_axi) chk("axi_timeout", 0, 1);
    bus.axi_req = 1'b0;
  endtask

  // One requester pair driven for n cycles; a pending request holds its qualifiers.
  task automatic traffic(input int n, input int p_axi, input int p_vid,
                         input int p_we, input int amax);
    for (int k = 0; k < n; k++) begin
      if (!a_pend && int'($urandom_range(99)) < p_axi) begin
        a_pend        = 1'b1;
        bus.axi_we    = (int'($urandom_range(99)) < p_we);
        bus.axi_addr  = 11'($urandom_range(amax));
        bus.axi_wdata = $urandom;
        bus.axi_wstrb = 4'($urandom_range(15));
      end
      if (!v_pend && int'($urandom_range(99)) < p_vid) begin
        v_pend       = 1'b1;
        bus.vid_addr = 11'($urandom_range(amax));
      end
      bus.axi_req = a_pend;
      bus.vid_req = v_pend;
      step();
      if (g_axi) a_pend = 1'b0;
      if (g_vid) v_pend = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((a_pend || v_pend) && t < 60) begin
      traffic(1, 0, 0, 0, 63);
      t++;
    end
    if (a_pend || v_pend) chk("drain_timeout", 0, 1);
    bus.axi_req = 1'b0;
    bus.vid_req = 1'b0;
    repeat (RD_LAT + 2) step();
  endtask

  initial begin
    int run, nax, cnt, t;
    logic [15:0] s0;
    bus.axi_req = 1'b1; bus.axi_we = 1'b0; bus.axi_addr = '0;
    bus.axi_wdata = '0; bus.axi_wstrb = '0;
    bus.vid_req = 1'b1; bus.vid_addr = '0;
    S_AXI_ARESET = 1'b1;
    @(posedge S_AXI_ACLK);
    #1;
    // Requests held high during reset must be ignored
    repeat (3) step();
    S_AXI_ARESET = 1'b0;
    bus.axi_req = 1'b0;
    bus.vid_req = 1'b0;
    chk("rst_starve", starve_events, 0);

    // Single write then read, then a byte-strobed merge
    axi_issue(1'b1, 11'h010, 32'hDEADBEEF, 4'hF);
    axi_issue(1'b0, 11'h010, 32'h0, 4'h0);
    repeat (3) step();
    chk("rd_beef", bus.axi_rdata, 32'hDEADBEEF);
    axi_issue(1'b1, 11'h010, 32'h11223344, 4'b0101);
    axi_issue(1'b0, 11'h010, 32'h0, 4'h0);
    repeat (3) step();
    chk("rd_strb", bus.axi_rdata, 32'hDE22BE44);

    // Tagged contents for every address used later; back-to-back grants
    for (int a = 0; a < 64; a++) axi_issue(1'b1, 11'(a), {16'hA5C3, 5'd0, 11'(a)}, 4'hF);
    step();

    // Interleaved reads: AXI always reading, video on roughly every other cycle
    traffic(40, 100, 50, 0, 63);
    drain();

    // Collision: both always requesting
    run = 0;
    nax = 0;
    s0  = starve_events;
    for (int k = 0; k < 60; k++) begin
      traffic(1, 100, 100, 30, 63);
      if (o_vid) run++;
      if (o_axi) begin
        chk("burst_len", run, MAX_VID_BURST);
        run = 0;
        nax++;
      end
    end
    chk("starve_delta", starve_events - s0, nax);
    drain();

    // Reset one cycle after a video grant: that read never returns
    bus.vid_addr = 11'h021;
    bus.vid_req  = 1'b1;
    t = 0;
    do begin step(); t++; end while (!g_vid && t < 20);
    if (!g_vid) chk("vid_timeout", 0, 1);
    bus.vid_req  = 1'b0;
    bus.axi_req  = 1'b1; bus.axi_we = 1'b0; bus.axi_addr = 11'h022;
    S_AXI_ARESET = 1'b1;
    cnt = 0;
    repeat (2) begin step(); cnt += int'(o_vrv); end
    S_AXI_ARESET = 1'b0;
    step();
    chk("resume_gnt", o_axi, 1);
    bus.axi_req = 1'b0;
    repeat (4) begin step(); cnt += int'(o_vrv); end
    chk("rst_drop_vrv", cnt, 0);

    // Idle
    s0  = starve_events;
    cnt = 0;
    repeat (20) begin step(); cnt += int'(o_men) + int'(o_axi) + int'(o_vid); end
    chk("idle_activity", cnt, 0);
    chk("idle_starve", starve_events, s0);

    // Random mixed traffic over a small address window
    traffic(150, 60, 60, 40, 15);
    traffic(150, 90, 80, 50, 63);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
